// File: rtl/usb_rx_ctrl.sv
// USB full-speed receive control: sequences one packet from the edge/EOP front end,
// validates SYNC, strobes data bytes into the RX FIFO and flags framing errors.
module usb_rx_ctrl #(
    parameter logic [7:0]  SYNC_BYTE = 8'h80,
    parameter int unsigned MAX_BYTES = 64,
    parameter int unsigned CNT_W     = 7
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             d_edge,
    input  logic             eop,
    input  logic             shift_enable,
    input  logic             byte_received,
    input  logic [7:0]       rcv_data,
    output logic             rcving,
    output logic             w_enable,
    output logic             r_error,
    output logic [CNT_W-1:0] byte_count
);

    typedef enum logic [3:0] {
        IDLE,
        SYNC_RCV,
        SYNC_CHK,
        BYTE_RCV,
        STORE,
        BOUNDARY,
        EOP_WAIT,
        ERR_WAIT,
        ERR_EOP,
        EIDLE
    } state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BYTES);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             at_max;
    logic             eop_sample;

    assign at_max     = (cnt_q == MAX_CNT);
    assign eop_sample = eop & shift_enable;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (d_edge) begin
                    state_d = SYNC_RCV;
                    cnt_d   = '0;
                end
            end
            SYNC_RCV: begin
                if (byte_received) begin
                    state_d = SYNC_CHK;
                end else if (eop_sample) begin
                    state_d = ERR_EOP;
                end
            end
            SYNC_CHK: begin
                state_d = (rcv_data == SYNC_BYTE) ? BYTE_RCV : ERR_WAIT;
            end
            BYTE_RCV: begin
                // A completed byte wins over an EOP sampled in the same cycle.
                if (byte_received) begin
                    state_d = STORE;
                end else if (eop_sample) begin
                    state_d = ERR_EOP;
                end
            end
            STORE: begin
                if (at_max) begin
                    state_d = ERR_WAIT;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = BOUNDARY;
                end
            end
            BOUNDARY: begin
                if (shift_enable) begin
                    state_d = eop ? EOP_WAIT : BYTE_RCV;
                end
            end
            EOP_WAIT: begin
                if (d_edge) begin
                    state_d = IDLE;
                end
            end
            ERR_WAIT: begin
                if (eop_sample) begin
                    state_d = ERR_EOP;
                end
            end
            ERR_EOP: begin
                if (d_edge) begin
                    state_d = EIDLE;
                end
            end
            EIDLE: begin
                if (d_edge) begin
                    state_d = SYNC_RCV;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        rcving     = (state_q != IDLE) && (state_q != EIDLE);
        w_enable   = (state_q == STORE) && !at_max;
        // The overflowing byte raises the error already in its STORE cycle.
        r_error    = (state_q == ERR_WAIT) || (state_q == ERR_EOP) ||
                     (state_q == EIDLE) || ((state_q == STORE) && at_max);
        byte_count = cnt_q;
    end

endmodule

// File: tb/tb_usb_rx_ctrl.sv
// Randomized packet-level bench for usb_rx_ctrl: drives bit-timed packets and compares
// FIFO writes, byte count and error/receive flags against a packet-level model.
module tb_usb_rx_ctrl;

    localparam int unsigned MAXB = 4;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       d_edge;
    logic       eop;
    logic       shift_enable;
    logic       byte_received;
    logic [7:0] rcv_data;
    logic       rcving;
    logic       w_enable;
    logic       r_error;
    logic [6:0] byte_count;

    usb_rx_ctrl #(
        .SYNC_BYTE (8'h80),
        .MAX_BYTES (MAXB),
        .CNT_W     (7)
    ) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .d_edge        (d_edge),
        .eop           (eop),
        .shift_enable  (shift_enable),
        .byte_received (byte_received),
        .rcv_data      (rcv_data),
        .rcving        (rcving),
        .w_enable      (w_enable),
        .r_error       (r_error),
        .byte_count    (byte_count)
    );

    always #5 clk = ~clk;

    int unsigned n_pass = 0;
    int unsigned n_chk  = 0;
    logic [7:0]  got_q[$];
    logic [7:0]  pkt[8];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        if (w_enable === 1'b1) got_q.push_back(rcv_data);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // kind: 0 none, 1 check SYNC verdict (exp = error), 2 check write strobe (exp = w_enable)
    task automatic drive_bit(input bit is_eop, input bit brx, input logic [7:0] data,
                             input int kind, input bit exp);
        shift_enable = 1'b1;
        eop          = is_eop;
        tick();
        shift_enable = 1'b0;
        if (brx) begin
            byte_received = 1'b1;
            rcv_data      = data;
        end
        tick();
        byte_received = 1'b0;
        if (kind == 2) check("w_enable_latency", w_enable, exp);
        tick();
        if (kind == 1) check("sync_verdict", r_error, exp);
        for (int c = 3; c < 8; c++) begin
            d_edge = (c == 4 && !is_eop) ? 1'($urandom % 2) : 1'b0;
            tick();
            d_edge = 1'b0;
        end
    endtask

    task automatic drive_byte(input logic [7:0] data, input int kind, input bit exp);
        for (int b = 0; b < 8; b++) drive_bit(1'b0, b == 7, data, (b == 7) ? kind : 0, exp);
    endtask

    // trunc >= 0: EOP after that many bits of the SYNC byte; mid > 0: EOP after mid bits
    // of a byte following the n full data bytes held in pkt.
    task automatic send_packet(input logic [7:0] sync, input int n, input int trunc, input int mid);
        bit sync_ok;
        int nw;
        bit exp_err;
        sync_ok = (trunc < 0) && (sync == 8'h80);
        if (!sync_ok) begin
            nw      = 0;
            exp_err = 1'b1;
        end else begin
            nw      = (n > int'(MAXB)) ? int'(MAXB) : n;
            exp_err = (n > int'(MAXB)) || (mid > 0) || (n == 0);
        end

        check("idle_rcving", rcving, 0);
        got_q.delete();
        d_edge = 1'b1;
        tick();
        d_edge = 1'b0;
        check("start_rcving", rcving, 1);
        check("start_r_error", r_error, 0);
        check("start_count", byte_count, 0);

        if (trunc >= 0) begin
            for (int k = 0; k < trunc; k++) drive_bit(1'b0, 1'b0, 8'h00, 0, 1'b0);
        end else begin
            drive_byte(sync, 1, !sync_ok);
            for (int i = 0; i < n; i++) drive_byte(pkt[i], 2, sync_ok && (i < int'(MAXB)));
            for (int k = 0; k < mid; k++) drive_bit(1'b0, 1'b0, 8'h00, 0, 1'b0);
        end
        drive_bit(1'b1, 1'b0, 8'h00, 0, 1'b0);
        drive_bit(1'b1, 1'b0, 8'h00, 0, 1'b0);
        check("eop_rcving", rcving, 1);
        eop    = 1'b0;
        d_edge = 1'b1;
        tick();
        d_edge = 1'b0;

        check("end_rcving", rcving, 0);
        check("end_r_error", r_error, exp_err);
        check("end_count", byte_count, nw);
        check("write_count", got_q.size(), nw);
        if (got_q.size() == nw) begin
            for (int i = 0; i < nw; i++) check("write_data", got_q[i], pkt[i]);
        end
        tick();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        n_rst         = 1'b0;
        d_edge        = 1'b0;
        eop           = 1'b0;
        shift_enable  = 1'b0;
        byte_received = 1'b0;
        rcv_data      = 8'h00;
        #12;
        check("rst_rcving", rcving, 0);
        check("rst_w_enable", w_enable, 0);
        check("rst_r_error", r_error, 0);
        check("rst_count", byte_count, 0);
        n_rst = 1'b1;
        tick();
        tick();

        pkt[0] = 8'hA5; pkt[1] = 8'h3C;
        send_packet(8'h80, 2, -1, 0);
        send_packet(8'h81, 0, -1, 0);
        pkt[0] = 8'h42;
        send_packet(8'h80, 1, -1, 0);
        pkt[0] = 8'h11;
        send_packet(8'h80, 1, -1, 3);
        for (int i = 0; i < 5; i++) pkt[i] = 8'(8'h20 + i);
        send_packet(8'h80, 5, -1, 0);
        pkt[0] = 8'h5A; pkt[1] = 8'hC3; pkt[2] = 8'h0F; pkt[3] = 8'hF0;
        send_packet(8'h80, 4, -1, 0);

        // asynchronous reset in the middle of a data byte
        got_q.delete();
        d_edge = 1'b1;
        tick();
        d_edge = 1'b0;
        drive_byte(8'h80, 1, 1'b0);
        drive_byte(8'h77, 2, 1'b1);
        for (int k = 0; k < 3; k++) drive_bit(1'b0, 1'b0, 8'h00, 0, 1'b0);
        check("pre_rst_count", byte_count, 1);
        #2 n_rst = 1'b0;
        #1;
        check("async_rst_rcving", rcving, 0);
        check("async_rst_w_enable", w_enable, 0);
        check("async_rst_r_error", r_error, 0);
        check("async_rst_count", byte_count, 0);
        #2 n_rst = 1'b1;
        tick();
        pkt[0] = 8'h99;
        send_packet(8'h80, 1, -1, 0);

        for (int p = 0; p < 30; p++) begin
            logic [7:0] s;
            int n, trunc, mid;
            n = int'($urandom_range(0, 6));
            for (int i = 0; i < 8; i++) pkt[i] = 8'($urandom);
            s = 8'h80;
            if ($urandom_range(0, 5) == 0) s = 8'h80 ^ 8'(1 << $urandom_range(0, 7));
            trunc = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : -1;
            mid   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
            send_packet(s, n, trunc, mid);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
